// File: rtl/sys_clk_ctrl.sv
// sys_clk_ctrl: clock/reset supervisor placed directly after the board PLL.
// Synchronises and filters PLL lock, releases per-channel resets in a fixed
// staggered order, generates per-channel clock-enable strobes, and counts
// lock-loss events. Any lock loss returns every channel to reset.
module sys_clk_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 1024,
  parameter int STAGGER     = 16,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic                    lost_clr,
  output logic [NUM_CH-1:0]       rst_out_n,
  output logic [NUM_CH-1:0]       ce,
  output logic                    locked_out,
  output logic [CNT_W-1:0]        lost_cnt
);

  localparam int FILT_W = $clog2(LOCK_CYCLES + 1);
  localparam int STG_W  = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_CYCLES - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]  LOST_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2
  } state_e;

  // Saturating increment used by the lock-loss counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == LOST_MAX) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Lock synchroniser and supervisor state
  logic               sync1_q, sync2_q;
  logic               locked_s;
  state_e             state_q;
  logic [FILT_W-1:0]  filt_q;
  logic [STG_W-1:0]   stg_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_CH-1:0]  rst_out_n_q, rst_out_n_d;
  logic               locked_out_q;
  logic [CNT_W-1:0]   lost_cnt_q;

  // Per-edge events derived from the current state
  logic               loss_s;
  logic [NUM_CH-1:0]  rel_vec_s;

  // Per-channel divider state
  logic [DIV_W-1:0]   cfg_s  [NUM_CH];
  logic [DIV_W-1:0]   div_q  [NUM_CH];
  logic [DIV_W-1:0]   div_d  [NUM_CH];
  logic [DIV_W-1:0]   cnt_q  [NUM_CH];
  logic [DIV_W-1:0]   cnt_d  [NUM_CH];
  logic [NUM_CH-1:0]  wrap_s;
  logic [NUM_CH-1:0]  ce_q, ce_d;

  assign locked_s = sync2_q;

  // Two-flop synchroniser; the only sampler of the asynchronous pll_locked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Decode this edge's lock-loss and channel-release events and next resets.
  always_comb begin
    loss_s    = 1'b0;
    rel_vec_s = '0;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s && (filt_q == FILT_LAST)) begin
          rel_vec_s[0] = 1'b1;
        end else begin
          rel_vec_s = '0;
        end
      end
      RELEASE: begin
        if (!locked_s) begin
          loss_s = 1'b1;
        end else if (stg_q == STG_LAST) begin
          rel_vec_s[idx_q] = 1'b1;
        end else begin
          loss_s = 1'b0;
        end
      end
      RUN: begin
        if (!locked_s) begin
          loss_s = 1'b1;
        end else begin
          loss_s = 1'b0;
        end
      end
      default: begin
        loss_s    = 1'b0;
        rel_vec_s = '0;
      end
    endcase
    if (loss_s) begin
      rst_out_n_d = '0;
    end else begin
      rst_out_n_d = rst_out_n_q | rel_vec_s;
    end
  end

  // Supervisor FSM: lock filter, staggered release, lock-loss handling and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= WAIT_LOCK;
      filt_q       <= '0;
      stg_q        <= '0;
      idx_q        <= '0;
      rst_out_n_q  <= '0;
      locked_out_q <= 1'b0;
      lost_cnt_q   <= '0;
    end else begin
      rst_out_n_q <= rst_out_n_d;
      case (state_q)
        WAIT_LOCK: begin
          if (!locked_s) begin
            filt_q <= '0;
          end else if (filt_q == FILT_LAST) begin
            filt_q <= '0;
            stg_q  <= '0;
            if (NUM_CH == 1) begin
              state_q      <= RUN;
              locked_out_q <= 1'b1;
            end else begin
              state_q <= RELEASE;
              idx_q   <= IDX_W'(1);
            end
          end else begin
            filt_q <= filt_q + FILT_W'(1);
          end
        end
        RELEASE: begin
          if (!locked_s) begin
            state_q      <= WAIT_LOCK;
            filt_q       <= '0;
            locked_out_q <= 1'b0;
          end else if (stg_q == STG_LAST) begin
            stg_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q      <= RUN;
              locked_out_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            stg_q <= stg_q + STG_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_q      <= WAIT_LOCK;
            filt_q       <= '0;
            locked_out_q <= 1'b0;
          end else begin
            locked_out_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= WAIT_LOCK;
          filt_q       <= '0;
          locked_out_q <= 1'b0;
        end
      endcase
      // A clear that coincides with a counted loss leaves exactly that one loss.
      if (loss_s) begin
        if (lost_clr) begin
          lost_cnt_q <= CNT_W'(1);
        end else begin
          lost_cnt_q <= sat_inc(lost_cnt_q);
        end
      end else if (lost_clr) begin
        lost_cnt_q <= '0;
      end else begin
        lost_cnt_q <= lost_cnt_q;
      end
    end
  end

  // Divider next state: hold in reset, (re)load divisor on release/wrap, else count.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cfg_s[k]  = div_cfg[k*DIV_W +: DIV_W];
      wrap_s[k] = (div_q[k] <= DIV_W'(1)) || (cnt_q[k] == (div_q[k] - DIV_W'(1)));
      div_d[k]  = div_q[k];
      cnt_d[k]  = cnt_q[k];
      ce_d[k]   = 1'b0;
      if (!rst_out_n_d[k]) begin
        cnt_d[k] = '0;
        ce_d[k]  = 1'b0;
      end else if (!rst_out_n_q[k] || wrap_s[k]) begin
        // New period: strobe immediately only for a pass-through divisor.
        div_d[k] = cfg_s[k];
        cnt_d[k] = '0;
        ce_d[k]  = (cfg_s[k] <= DIV_W'(1));
      end else begin
        cnt_d[k] = cnt_q[k] + DIV_W'(1);
        ce_d[k]  = ((cnt_q[k] + DIV_W'(1)) == (div_q[k] - DIV_W'(1)));
      end
    end
  end

  // Divider registers and registered clock-enable strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        div_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      ce_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        div_q[k] <= div_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      ce_q <= ce_d;
    end
  end

  assign rst_out_n  = rst_out_n_q;
  assign ce         = ce_q;
  assign locked_out = locked_out_q;
  assign lost_cnt   = lost_cnt_q;

endmodule

// File: tb/tb_sys_clk_ctrl.sv
// Directed self-checking bench for sys_clk_ctrl with NUM_CH=4, LOCK_CYCLES=8,
// STAGGER=4, CNT_W=2. Edge numbers count from the first edge at which
// pll_locked is driven high.
module tb_sys_clk_ctrl;

  logic        clk;
  logic        rst_n;
  logic        pll_locked;
  logic [31:0] div_cfg;
  logic        lost_clr;
  logic [3:0]  rst_out_n;
  logic [3:0]  ce;
  logic        locked_out;
  logic [1:0]  lost_cnt;

  int n_checks;
  int n_fail;
  int rise_e [4];
  int lk_e;

  sys_clk_ctrl #(
    .NUM_CH(4), .DIV_W(8), .LOCK_CYCLES(8), .STAGGER(4), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .div_cfg(div_cfg),
    .lost_clr(lost_clr), .rst_out_n(rst_out_n), .ce(ce),
    .locked_out(locked_out), .lost_cnt(lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected ce vector after edge e of the first lock run (div_cfg {0,1,3,5},
  // releases at 9/13/17/21, channel 0 divisor 5->2 written after edge 40).
  function automatic logic [3:0] exp_ce(input int e);
    logic [3:0] v;
    v    = 4'b0000;
    v[3] = (e >= 21);
    v[2] = (e >= 17);
    v[1] = (e >= 13) && (((e - 13) % 3) == 2);
    if (e <= 43) begin
      v[0] = (e >= 9) && (((e - 9) % 5) == 4);
    end else begin
      v[0] = (e >= 45) && (((e - 45) % 2) == 0);
    end
    return v;
  endfunction

  // Drive pll_locked high from edge 0 for n_edges edges, recording rise edges.
  task automatic run_seq(input int glitch_at, input int n_edges, input bit do_ce);
    for (int k = 0; k < 4; k++) rise_e[k] = -1;
    lk_e = -1;
    pll_locked = 1'b1;
    for (int e = 0; e < n_edges; e++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        if (rise_e[k] < 0 && rst_out_n[k]) rise_e[k] = e;
      end
      if (lk_e < 0 && locked_out) lk_e = e;
      if (do_ce) check_eq($sformatf("ce@%0d", e), 32'(ce), 32'(exp_ce(e)));
      if (do_ce && e == 40) div_cfg[7:0] = 8'd2;
      if (e + 1 == glitch_at) pll_locked = 1'b0;
      else if (e == glitch_at) pll_locked = 1'b1;
    end
  endtask

  task automatic check_rise(input string tag, input int first);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("%s_rise%0d", tag, k), rise_e[k], first + 4 * k);
    end
    check_eq($sformatf("%s_locked", tag), lk_e, first + 12);
  endtask

  task automatic lose();
    pll_locked = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    lost_clr   = 1'b0;
    div_cfg    = {8'd0, 8'd1, 8'd3, 8'd5};
    repeat (3) tick();
    check_eq("rst_rst_out_n", 32'(rst_out_n), 32'h0);
    check_eq("rst_ce", 32'(ce), 32'h0);
    check_eq("rst_locked", 32'(locked_out), 32'h0);
    check_eq("rst_lost", 32'(lost_cnt), 32'h0);

    // Initial lock with divider pattern and mid-period divisor change
    rst_n = 1'b1;
    run_seq(-1, 51, 1'b1);
    check_rise("lock1", 9);
    check_eq("lock1_lost", 32'(lost_cnt), 32'h0);

    // Loss in RUN: outputs drop at F0+2
    pll_locked = 1'b0;
    tick();
    tick();
    check_eq("loss_f1_rst", 32'(rst_out_n), 32'hF);
    check_eq("loss_f1_locked", 32'(locked_out), 32'h1);
    tick();
    check_eq("loss_f2_rst", 32'(rst_out_n), 32'h0);
    check_eq("loss_f2_ce", 32'(ce), 32'h0);
    check_eq("loss_f2_locked", 32'(locked_out), 32'h0);
    check_eq("loss_f2_lost", 32'(lost_cnt), 32'h1);

    // Relock repeats the full sequence
    tick();
    tick();
    run_seq(-1, 30, 1'b0);
    check_rise("relock", 9);
    check_eq("relock_lost", 32'(lost_cnt), 32'h1);

    // Glitch while filter is at 5 restarts the filter, not counted
    lose();
    check_eq("loss2_lost", 32'(lost_cnt), 32'h2);
    tick();
    run_seq(5, 40, 1'b0);
    check_rise("glitch", 15);
    check_eq("glitch_lost", 32'(lost_cnt), 32'h2);

    // Saturation and coincident clear
    lose();
    check_eq("loss3_lost", 32'(lost_cnt), 32'h3);
    tick();
    run_seq(-1, 12, 1'b0);
    check_eq("partial_rise0", rise_e[0], 9);
    lose();
    check_eq("loss4_sat", 32'(lost_cnt), 32'h3);
    check_eq("loss4_rst", 32'(rst_out_n), 32'h0);
    tick();
    run_seq(-1, 12, 1'b0);
    pll_locked = 1'b0;
    tick();
    tick();
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    check_eq("loss5_clr", 32'(lost_cnt), 32'h1);

    // Reset mid-RELEASE after channel 1 is out
    tick();
    run_seq(-1, 15, 1'b0);
    check_eq("midrel_rise1", rise_e[1], 13);
    rst_n = 1'b0;
    tick();
    check_eq("midrst_rst", 32'(rst_out_n), 32'h0);
    check_eq("midrst_ce", 32'(ce), 32'h0);
    check_eq("midrst_locked", 32'(locked_out), 32'h0);
    check_eq("midrst_lost", 32'(lost_cnt), 32'h0);
    rst_n = 1'b1;
    run_seq(-1, 30, 1'b0);
    check_rise("postrst", 9);
    check_eq("postrst_lost", 32'(lost_cnt), 32'h0);

    // Standalone clear
    lose();
    check_eq("loss6_lost", 32'(lost_cnt), 32'h1);
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    check_eq("clr_only", 32'(lost_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_clk_ctrl.md
Name: sys_clk_ctrl

Overview:
Parametrised clock/reset supervisor that sits directly after the board PLL and feeds all downstream domains. It synchronises and filters the PLL lock indication and releases NUM_CH per-channel resets in a fixed staggered order. It also generates a programmable clock-enable strobe per channel from the single system clock, and counts lock-loss events. On any loss of lock it returns every channel to reset.

Parameters:
NUM_CH, 4, number of output channels (1..16)
DIV_W, 8, width of each per-channel divisor field
LOCK_CYCLES, 1024, consecutive synchronised-lock cycles required before release (>=1)
STAGGER, 16, cycles between successive channel reset releases (>=1)
CNT_W, 8, width of the lock-loss event counter

Ports:
clk  in  1  system clock; sole clock of the block
rst_n  in  1  synchronous, active-low reset
pll_locked  in  1  PLL lock indication; asynchronous to clk
div_cfg  in  NUM_CH*DIV_W  divisor for channel k in bits [k*DIV_W +: DIV_W]
lost_clr  in  1  single-cycle pulse; clears lost_cnt
rst_out_n  out  NUM_CH  per-channel active-low reset
ce  out  NUM_CH  per-channel clock-enable strobe
locked_out  out  1  high only when all channels are released and lock is stable
lost_cnt  out  CNT_W  saturating count of lock-loss events

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rst_out_n=0, ce=0, locked_out=0, lost_cnt=0.
  - Synchroniser flops, filter counter, stagger counter and divider counters all cleared.
  - State WAIT_LOCK.
  - Applies identically mid-operation.
- Synchroniser: two flops; locked_s is pll_locked delayed two edges. No other logic samples pll_locked.
- States: WAIT_LOCK, RELEASE, RUN.
- WAIT_LOCK:
  - Filter counter increments on each edge with locked_s=1 and clears on any edge with locked_s=0.
  - When it reaches LOCK_CYCLES: rst_out_n[0]=1 on that same edge, stagger counter cleared, go to RELEASE.
  - Timing: with pll_locked first sampled high at edge E0 and held, rst_out_n[0] rises at edge E0+1+LOCK_CYCLES.
- RELEASE:
  - rst_out_n[k] rises exactly k*STAGGER edges after rst_out_n[0].
  - Released channels stay released.
  - On the edge releasing channel NUM_CH-1: locked_out=1 and go to RUN.
  - If NUM_CH=1, go straight from WAIT_LOCK to RUN and raise locked_out together with rst_out_n[0].
- Lock loss (locked_s=0 while in RELEASE or RUN):
  - On the next edge: all rst_out_n=0, all ce=0, locked_out=0, filter counter cleared.
  - lost_cnt increments, saturating at 2^CNT_W-1. Go to WAIT_LOCK.
  - Timing: pll_locked first sampled low at edge F0 gives outputs low at edge F0+2.
  - A loss during WAIT_LOCK is not counted.
- lost_clr: clears lost_cnt. If it coincides with a counted loss, the result is 1.
- Clock enables (channel k, only while rst_out_n[k]=1):
  - A latched divisor Dk is loaded from div_cfg on the release edge and on every wrap.
  - If Dk<=1, ce[k]=1 every cycle.
  - Otherwise a counter counts 0..Dk-1 and ce[k]=1 during the cycle the counter equals Dk-1; the counter then wraps to 0 and Dk is reloaded.
  - The first ce[k] pulse occurs Dk cycles after release.
  - A div_cfg change mid-period takes effect only at the next wrap.
  - While rst_out_n[k]=0: counter=0 and ce[k]=0.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- NUM_CH=4, LOCK_CYCLES=8, STAGGER=4; rst_n released, pll_locked high from edge 0 -> rst_out_n[0..3] rise at edges 9, 13, 17, 21; locked_out rises at 21; lost_cnt=0.
- Lock glitch: pll_locked low for one edge while the filter counter is at 5 -> filter restarts; release is delayed by a full 8 further locked_s cycles; lost_cnt unchanged.
- Loss in RUN: pll_locked low at edge F0 -> all rst_out_n, ce and locked_out are 0 at F0+2; lost_cnt=1. Relock -> full sequence repeats.
- Dividers: div_cfg = {8'd0, 8'd1, 8'd3, 8'd5} (channels 3..0) -> ce[3], ce[2] constant high; ce[1] period 3; ce[0] period 5. Channel 0's divisor changed 5->2 mid-period -> the current period completes at 5, then period 2.
- Saturation/clear: CNT_W=2; force 4 losses -> lost_cnt=3. lost_clr coincident with a 5th loss -> lost_cnt=1.
- Reset mid-RELEASE: rst_n=0 after channel 1 is released -> all outputs 0 on the next edge; after rst_n=1, the sequence restarts from WAIT_LOCK with lost_cnt=0.
